// File: rtl/mt_ckpt.sv
// mt_ckpt: rename map table with intra-group bypass, per-PR ready tracking and
// branch checkpoints that restore the whole map in one cycle on a mispredict.
module mt_ckpt #(
    parameter int unsigned NAR   = 32,
    parameter int unsigned NPR   = 128,
    parameter int unsigned WAYS  = 2,
    parameter int unsigned CDB_N = 4,
    parameter int unsigned NCKPT = 4,
    localparam int unsigned AR_W = $clog2(NAR),
    localparam int unsigned PR_W = $clog2(NPR),
    localparam int unsigned CK_W = $clog2(NCKPT)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WAYS-1:0]        disp_valid,
    input  logic [WAYS-1:0]        dest_valid,
    input  logic [WAYS*AR_W-1:0]   dest_ar,
    input  logic [WAYS*PR_W-1:0]   fl_pr,
    input  logic [WAYS*AR_W-1:0]   src1_ar,
    input  logic [WAYS*AR_W-1:0]   src2_ar,
    input  logic [WAYS-1:0]        ckpt_req,
    output logic [WAYS*PR_W-1:0]   src1_pr,
    output logic [WAYS*PR_W-1:0]   src2_pr,
    output logic [WAYS-1:0]        src1_ready,
    output logic [WAYS-1:0]        src2_ready,
    output logic [WAYS*PR_W-1:0]   told,
    output logic [CK_W-1:0]        ckpt_id,
    output logic                   ckpt_full,
    output logic                   ckpt_overflow,
    input  logic [CDB_N-1:0]       cdb_valid,
    input  logic [CDB_N*PR_W-1:0]  cdb_pr_tag,
    input  logic                   br_valid,
    input  logic                   br_mispredict,
    input  logic [CK_W-1:0]        br_ckpt_id
);

    localparam int unsigned CNT_W = CK_W + 1;

    logic [NAR-1:0][PR_W-1:0]             map_q, map_n, grp_map, snap_map;
    logic [NAR-1:0]                       grp_byp;
    logic [NCKPT-1:0][NAR-1:0][PR_W-1:0]  ckpt_q;
    logic [NPR-1:0]                       ready_q, ready_n;
    logic [CK_W-1:0]                      head_q, head_n, tail_q, tail_n;
    logic [CNT_W-1:0]                     count_q, count_n;
    logic                                 overflow_q;
    logic                                 ckpt_any, drop, mispredict, upd, resolve, alloc;

    // Registered ready bit OR a same-cycle CDB broadcast of that tag.
    function automatic logic pr_ready(input logic [PR_W-1:0] pr, input logic [NPR-1:0] rdy,
                                      input logic [CDB_N-1:0] cv, input logic [CDB_N*PR_W-1:0] ct);
        logic r;
        r = rdy[pr];
        for (int c = 0; c < CDB_N; c++) begin
            if (cv[c] && (ct[c*PR_W +: PR_W] == pr)) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [CK_W-1:0] ptr_inc(input logic [CK_W-1:0] p);
        return (p == CK_W'(NCKPT - 1)) ? '0 : p + CK_W'(1);
    endfunction

    // In-order group rename; grp_map holds the map as seen after each earlier way.
    always_comb begin
        grp_map    = map_q;
        grp_byp    = '0;
        snap_map   = map_q;
        ckpt_any   = 1'b0;
        src1_pr    = '0;
        src2_pr    = '0;
        src1_ready = '0;
        src2_ready = '0;
        told       = '0;
        for (int k = 0; k < WAYS; k++) begin
            src1_pr[k*PR_W +: PR_W] = grp_map[src1_ar[k*AR_W +: AR_W]];
            src2_pr[k*PR_W +: PR_W] = grp_map[src2_ar[k*AR_W +: AR_W]];
            src1_ready[k] = !grp_byp[src1_ar[k*AR_W +: AR_W]] &&
                            pr_ready(grp_map[src1_ar[k*AR_W +: AR_W]], ready_q, cdb_valid, cdb_pr_tag);
            src2_ready[k] = !grp_byp[src2_ar[k*AR_W +: AR_W]] &&
                            pr_ready(grp_map[src2_ar[k*AR_W +: AR_W]], ready_q, cdb_valid, cdb_pr_tag);
            told[k*PR_W +: PR_W] = grp_map[dest_ar[k*AR_W +: AR_W]];
            if (disp_valid[k] && dest_valid[k]) begin
                grp_map[dest_ar[k*AR_W +: AR_W]] = fl_pr[k*PR_W +: PR_W];
                grp_byp[dest_ar[k*AR_W +: AR_W]] = 1'b1;
            end
            if (disp_valid[k] && ckpt_req[k]) begin
                snap_map = grp_map;
                ckpt_any = 1'b1;
            end
        end
    end

    assign ckpt_full     = (count_q == CNT_W'(NCKPT));
    assign ckpt_id       = tail_q;
    assign ckpt_overflow = overflow_q;
    assign mispredict    = br_valid && br_mispredict;
    assign drop          = ckpt_any && ckpt_full;
    assign upd           = !mispredict && !drop;
    assign alloc         = upd && ckpt_any;
    assign resolve       = br_valid && !br_mispredict && (count_q != '0);

    assign map_n = mispredict ? ckpt_q[br_ckpt_id] : (upd ? grp_map : map_q);

    // CDB sets first so a same-cycle allocation of that PR clears it.
    always_comb begin
        ready_n = ready_q;
        for (int c = 0; c < CDB_N; c++) begin
            if (cdb_valid[c]) ready_n[cdb_pr_tag[c*PR_W +: PR_W]] = 1'b1;
        end
        if (upd) begin
            for (int k = 0; k < WAYS; k++) begin
                if (disp_valid[k] && dest_valid[k]) ready_n[fl_pr[k*PR_W +: PR_W]] = 1'b0;
            end
        end
    end

    // Mispredict discards the branch's slot and everything younger.
    always_comb begin
        head_n  = head_q;
        tail_n  = tail_q;
        count_n = count_q;
        if (mispredict) begin
            tail_n  = br_ckpt_id;
            count_n = (br_ckpt_id >= head_q)
                    ? CNT_W'(br_ckpt_id) - CNT_W'(head_q)
                    : CNT_W'(NCKPT) + CNT_W'(br_ckpt_id) - CNT_W'(head_q);
        end else begin
            if (resolve) head_n = ptr_inc(head_q);
            if (alloc)   tail_n = ptr_inc(tail_q);
            count_n = count_q + CNT_W'(alloc) - CNT_W'(resolve);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NAR; i++) map_q[i] <= PR_W'(i);
            ready_q    <= NPR'({NAR{1'b1}});
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            map_q   <= map_n;
            ready_q <= ready_n;
            head_q  <= head_n;
            tail_q  <= tail_n;
            count_q <= count_n;
            if (drop && !mispredict) overflow_q <= 1'b1;
        end
    end

    // Snapshot storage needs no reset; a slot is only read after being written.
    always_ff @(posedge clock) begin
        if (!reset && alloc) ckpt_q[tail_q] <= snap_map;
    end

endmodule

// File: tb/tb_mt_ckpt.sv
// Self-checking bench for mt_ckpt: expectations are queued as stimulus is
// driven and popped against the settled combinational outputs each cycle.
module tb_mt_ckpt;

    localparam int unsigned NAR = 32, NPR = 128, WAYS = 2, CDB_N = 4, NCKPT = 4;
    localparam int unsigned AR_W = 5, PR_W = 7, CK_W = 2;
    localparam int S1 = 0, S2 = 1, R1 = 2, R2 = 3, TOLD = 4, CKID = 5, FULL = 6, OVF = 7;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [WAYS-1:0]       disp_valid, dest_valid, ckpt_req;
    logic [WAYS*AR_W-1:0]  dest_ar, src1_ar, src2_ar;
    logic [WAYS*PR_W-1:0]  fl_pr, src1_pr, src2_pr, told;
    logic [WAYS-1:0]       src1_ready, src2_ready;
    logic [CK_W-1:0]       ckpt_id, br_ckpt_id;
    logic                  ckpt_full, ckpt_overflow, br_valid, br_mispredict;
    logic [CDB_N-1:0]      cdb_valid;
    logic [CDB_N*PR_W-1:0] cdb_pr_tag;

    typedef struct {
        string       name;
        int          sel;
        int          way;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    mt_ckpt #(.NAR(NAR), .NPR(NPR), .WAYS(WAYS), .CDB_N(CDB_N), .NCKPT(NCKPT)) dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .dest_valid(dest_valid), .dest_ar(dest_ar), .fl_pr(fl_pr),
        .src1_ar(src1_ar), .src2_ar(src2_ar), .ckpt_req(ckpt_req),
        .src1_pr(src1_pr), .src2_pr(src2_pr), .src1_ready(src1_ready), .src2_ready(src2_ready),
        .told(told), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full), .ckpt_overflow(ckpt_overflow),
        .cdb_valid(cdb_valid), .cdb_pr_tag(cdb_pr_tag),
        .br_valid(br_valid), .br_mispredict(br_mispredict), .br_ckpt_id(br_ckpt_id)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] observe(input int sel, input int way);
        case (sel)
            S1:      return 32'(src1_pr[way*PR_W +: PR_W]);
            S2:      return 32'(src2_pr[way*PR_W +: PR_W]);
            R1:      return 32'(src1_ready[way]);
            R2:      return 32'(src2_ready[way]);
            TOLD:    return 32'(told[way*PR_W +: PR_W]);
            CKID:    return 32'(ckpt_id);
            FULL:    return 32'(ckpt_full);
            default: return 32'(ckpt_overflow);
        endcase
    endfunction

    task automatic clear_inputs();
        reset = 1'b0; disp_valid = '0; dest_valid = '0; ckpt_req = '0;
        dest_ar = '0; src1_ar = '0; src2_ar = '0; fl_pr = '0;
        cdb_valid = '0; cdb_pr_tag = '0;
        br_valid = 1'b0; br_mispredict = 1'b0; br_ckpt_id = '0;
    endtask

    task automatic set_way(input int k, input int s1, input int s2, input bit dv,
                           input int dar, input int pr, input bit ck);
        disp_valid[k] = 1'b1;
        dest_valid[k] = dv;
        ckpt_req[k]   = ck;
        src1_ar[k*AR_W +: AR_W] = AR_W'(s1);
        src2_ar[k*AR_W +: AR_W] = AR_W'(s2);
        dest_ar[k*AR_W +: AR_W] = AR_W'(dar);
        fl_pr[k*PR_W +: PR_W]   = PR_W'(pr);
    endtask

    task automatic set_cdb(input int c, input int tag);
        cdb_valid[c] = 1'b1;
        cdb_pr_tag[c*PR_W +: PR_W] = PR_W'(tag);
    endtask

    task automatic want(input string n, input int sel, input int way, input int v);
        sb.push_back('{n, sel, way, 32'(v)});
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] obs;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clock);
            clear_inputs();
            reset = (cyc < 2);
            if (cyc == 2) begin
                want("rst_full", FULL, 0, 0);
                want("rst_ovf", OVF, 0, 0);
                want("rst_ckid", CKID, 0, 0);
            end
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.sel, e.way); tests++;
                if (obs !== e.exp) begin
                    failed++;
                    $display("FAIL %s way%0d: got %0d expected %0d", e.name, e.way, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_identity();
        exp_t e;
        logic [31:0] obs;
        int ar;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clock);
            clear_inputs();
            for (int k = 0; k < 2; k++) begin
                ar = 4 * cyc + 2 * k;
                set_way(k, ar, ar + 1, 1'b0, ar, 0, 1'b0);
                want("id_src1", S1, k, ar);
                want("id_src2", S2, k, ar + 1);
                want("id_rdy1", R1, k, 1);
                want("id_rdy2", R2, k, 1);
                want("id_told", TOLD, k, ar);
            end
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.sel, e.way); tests++;
                if (obs !== e.exp) begin
                    failed++;
                    $display("FAIL %s way%0d: got %0d expected %0d", e.name, e.way, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        logic [31:0] obs;
        for (int cyc = 0; cyc < 2; cyc++) begin
            @(negedge clock);
            clear_inputs();
            case (cyc)
                0: begin
                    set_way(0, 1, 2, 1'b1, 3, 40, 1'b0);
                    set_way(1, 3, 3, 1'b1, 3, 41, 1'b0);
                    want("byp_w0_src1", S1, 0, 1);
                    want("byp_w0_rdy1", R1, 0, 1);
                    want("byp_w0_told", TOLD, 0, 3);
                    want("byp_w1_src1", S1, 1, 40);
                    want("byp_w1_rdy1", R1, 1, 0);
                    want("byp_w1_src2", S2, 1, 40);
                    want("byp_w1_told", TOLD, 1, 40);
                end
                default: begin
                    set_way(0, 3, 4, 1'b0, 0, 0, 1'b0);
                    want("byp_next_src1", S1, 0, 41);
                    want("byp_next_rdy1", R1, 0, 0);
                    want("byp_next_src2", S2, 0, 4);
                    want("byp_next_rdy2", R2, 0, 1);
                end
            endcase
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.sel, e.way); tests++;
                if (obs !== e.exp) begin
                    failed++;
                    $display("FAIL %s way%0d: got %0d expected %0d", e.name, e.way, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_cdb();
        exp_t e;
        logic [31:0] obs;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clock);
            clear_inputs();
            case (cyc)
                0: begin
                    set_way(0, 3, 3, 1'b0, 0, 0, 1'b0);
                    cdb_pr_tag[0 +: PR_W] = PR_W'(41);
                    set_cdb(2, 41);
                    want("cdb_same_src1", S1, 0, 41);
                    want("cdb_same_rdy1", R1, 0, 1);
                end
                1: begin
                    set_way(0, 3, 3, 1'b0, 0, 0, 1'b0);
                    want("cdb_reg_rdy1", R1, 0, 1);
                    want("cdb_reg_rdy2", R2, 0, 1);
                end
                2: begin
                    set_way(0, 7, 7, 1'b1, 7, 60, 1'b0);
                    set_way(1, 7, 2, 1'b1, 8, 61, 1'b0);
                    set_cdb(0, 60);
                    set_cdb(1, 61);
                    want("cdb_w0_rdy1", R1, 0, 1);
                    want("cdb_byp_src1", S1, 1, 60);
                    want("cdb_byp_rdy1", R1, 1, 0);
                    want("cdb_w1_told", TOLD, 1, 8);
                end
                default: begin
                    set_way(0, 7, 8, 1'b0, 0, 0, 1'b0);
                    want("clr_win_src1", S1, 0, 60);
                    want("clr_win_rdy1", R1, 0, 0);
                    want("clr_win_src2", S2, 0, 61);
                    want("clr_win_rdy2", R2, 0, 0);
                end
            endcase
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.sel, e.way); tests++;
                if (obs !== e.exp) begin
                    failed++;
                    $display("FAIL %s way%0d: got %0d expected %0d", e.name, e.way, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_mispredict();
        exp_t e;
        logic [31:0] obs;
        for (int cyc = 0; cyc < 11; cyc++) begin
            @(negedge clock);
            clear_inputs();
            case (cyc)
                0: begin
                    set_way(0, 0, 0, 1'b0, 0, 0, 1'b1);
                    set_way(1, 5, 5, 1'b1, 5, 50, 1'b0);
                    want("mp_ckid", CKID, 0, 0);
                    want("mp_full0", FULL, 0, 0);
                    want("mp_w1_src1", S1, 1, 5);
                end
                1: begin
                    set_way(0, 5, 5, 1'b1, 6, 70, 1'b0);
                    br_valid = 1'b1; br_mispredict = 1'b1; br_ckpt_id = '0;
                    want("mp_renamed_src1", S1, 0, 50);
                    want("mp_renamed_rdy1", R1, 0, 0);
                    want("mp_told", TOLD, 0, 6);
                end
                2: begin
                    set_way(0, 5, 6, 1'b0, 0, 0, 1'b0);
                    want("mp_restore_src1", S1, 0, 5);
                    want("mp_restore_rdy1", R1, 0, 1);
                    want("mp_ignored_src2", S2, 0, 6);
                    want("mp_ignored_rdy2", R2, 0, 1);
                    want("mp_full", FULL, 0, 0);
                end
                3, 4, 5, 7: begin
                    set_way(0, 0, 0, 1'b0, 0, 0, 1'b1);
                    want("mp_refill_full", FULL, 0, 0);
                end
                6:  want("mp_cnt3_full", FULL, 0, 0);
                8:  want("mp_cnt4_full", FULL, 0, 1);
                9: begin
                    br_valid = 1'b1; br_ckpt_id = '0;
                    want("mp_resolve_full_now", FULL, 0, 1);
                end
                default: want("mp_resolved_full", FULL, 0, 0);
            endcase
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.sel, e.way); tests++;
                if (obs !== e.exp) begin
                    failed++;
                    $display("FAIL %s way%0d: got %0d expected %0d", e.name, e.way, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_full();
        exp_t e;
        logic [31:0] obs;
        for (int cyc = 0; cyc < 11; cyc++) begin
            @(negedge clock);
            clear_inputs();
            case (cyc)
                0: reset = 1'b1;
                1, 2, 3, 4: begin
                    set_way(0, 0, 0, 1'b0, 0, 0, 1'b1);
                    want("fill_ckid", CKID, 0, cyc - 1);
                    want("fill_full", FULL, 0, 0);
                end
                5: begin
                    set_way(0, 0, 0, 1'b0, 0, 0, 1'b1);
                    set_way(1, 9, 9, 1'b1, 9, 80, 1'b0);
                    want("ovf_full", FULL, 0, 1);
                    want("ovf_before", OVF, 0, 0);
                end
                6: begin
                    set_way(0, 9, 9, 1'b0, 0, 0, 1'b0);
                    want("drop_src1", S1, 0, 9);
                    want("drop_rdy1", R1, 0, 1);
                    want("ovf_set", OVF, 0, 1);
                end
                7: begin
                    br_valid = 1'b1; br_ckpt_id = 2'd0;
                    want("res_full_now", FULL, 0, 1);
                end
                8: begin
                    set_way(0, 0, 0, 1'b0, 0, 0, 1'b1);
                    br_valid = 1'b1; br_ckpt_id = 2'd1;
                    want("res_alloc_full", FULL, 0, 0);
                    want("res_alloc_ckid", CKID, 0, 0);
                end
                9: begin
                    set_way(0, 0, 0, 1'b0, 0, 0, 1'b1);
                    want("cnt_same_full", FULL, 0, 0);
                    want("cnt_same_ckid", CKID, 0, 1);
                end
                default: begin
                    want("refull", FULL, 0, 1);
                    want("ovf_sticky", OVF, 0, 1);
                end
            endcase
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.sel, e.way); tests++;
                if (obs !== e.exp) begin
                    failed++;
                    $display("FAIL %s way%0d: got %0d expected %0d", e.name, e.way, obs, e.exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [31:0] obs;
        for (int cyc = 0; cyc < 3; cyc++) begin
            @(negedge clock);
            clear_inputs();
            case (cyc)
                0: begin
                    set_way(0, 10, 10, 1'b1, 10, 90, 1'b0);
                    want("pre_rst_full", FULL, 0, 1);
                end
                1: begin
                    reset = 1'b1;
                    set_way(0, 10, 10, 1'b1, 11, 91, 1'b0);
                    br_valid = 1'b1; br_mispredict = 1'b1; br_ckpt_id = 2'd2;
                end
                default: begin
                    set_way(0, 10, 11, 1'b0, 0, 0, 1'b0);
                    want("rm_src1", S1, 0, 10);
                    want("rm_rdy1", R1, 0, 1);
                    want("rm_src2", S2, 0, 11);
                    want("rm_rdy2", R2, 0, 1);
                    want("rm_full", FULL, 0, 0);
                    want("rm_ovf", OVF, 0, 0);
                    want("rm_ckid", CKID, 0, 0);
                end
            endcase
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.sel, e.way); tests++;
                if (obs !== e.exp) begin
                    failed++;
                    $display("FAIL %s way%0d: got %0d expected %0d", e.name, e.way, obs, e.exp);
                end
            end
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_identity();
        test_bypass();
        test_cdb();
        test_mispredict();
        test_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
